// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator driven from CLOCK_50.
//   CLOCK_50    in   system clock
//   reset       in   synchronous active-high reset
//   pix_en      out  one-cycle pixel-tick strobe (every CLK_DIV cycles)
//   x, y        out  horizontal / vertical position counters (never delayed)
//   col, row    out  character-cell coordinates (x / CELL_W, y / CELL_H)
//   cell_px/py  out  position inside the character cell
//   active      out  visible-region flag, delayed SYNC_DELAY pixel ticks
//   blank_n     out  same as active
//   hsync/vsync out  programmable-polarity syncs, delayed SYNC_DELAY ticks
//   line_start  out  pix_en & x==0
//   frame_start out  pix_en & x==0 & y==0
//   frame_cnt   out  completed-frame counter (wraps)
//   blink       out  frame_cnt[BLINK_BIT]
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SYNC_DELAY = 0,
  parameter int unsigned CELL_W     = 8,
  parameter int unsigned CELL_H     = 16,
  parameter int unsigned BLINK_BIT  = 4,
  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW        = $clog2(H_TOTAL),
  localparam int unsigned YW        = $clog2(V_TOTAL),
  localparam int unsigned CWL       = $clog2(CELL_W),
  localparam int unsigned CHL       = $clog2(CELL_H)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  output logic              pix_en,
  output logic [XW-1:0]     x,
  output logic [YW-1:0]     y,
  output logic [XW-CWL-1:0] col,
  output logic [YW-CHL-1:0] row,
  output logic [CWL-1:0]    cell_px,
  output logic [CHL-1:0]    cell_py,
  output logic              active,
  output logic              blank_n,
  output logic              hsync,
  output logic              vsync,
  output logic              line_start,
  output logic              frame_start,
  output logic [15:0]       frame_cnt,
  output logic              blink
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] d;
  logic          active_r;
  logic          hs_r;
  logic          vs_r;

  // Pixel-tick divider; pix_en is registered so it is glitch-free and
  // asserted in the cycle after d reaches its last value.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      d      <= '0;
      pix_en <= 1'b0;
    end else begin
      pix_en <= (d == D_LAST);
      d      <= (d == D_LAST) ? '0 : d + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else if (pix_en) begin
      if (32'(x) == H_TOTAL - 1) begin
        x <= '0;
        if (32'(y) == V_TOTAL - 1) begin
          y         <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          y <= y + 1'b1;
        end
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_comb begin
    active_r = (32'(x) < H_ACTIVE) && (32'(y) < V_ACTIVE);
    hs_r     = ((32'(x) >= H_ACTIVE + H_FP) && (32'(x) < H_ACTIVE + H_FP + H_SYNC))
               ? HS_POL : ~HS_POL;
    vs_r     = ((32'(y) >= V_ACTIVE + V_FP) && (32'(y) < V_ACTIVE + V_FP + V_SYNC))
               ? VS_POL : ~VS_POL;
  end

  generate
    if (SYNC_DELAY == 0) begin : g_nodelay
      assign active = active_r;
      assign hsync  = hs_r;
      assign vsync  = vs_r;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] act_sr;
      logic [SYNC_DELAY-1:0] hs_sr;
      logic [SYNC_DELAY-1:0] vs_sr;

      // Stages advance only on pixel ticks so the lag is counted in pixels.
      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          act_sr <= '0;
          hs_sr  <= HS_POL ? '0 : '1;
          vs_sr  <= VS_POL ? '0 : '1;
        end else if (pix_en) begin
          act_sr[0] <= active_r;
          hs_sr[0]  <= hs_r;
          vs_sr[0]  <= vs_r;
          for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
            act_sr[i] <= act_sr[i-1];
            hs_sr[i]  <= hs_sr[i-1];
            vs_sr[i]  <= vs_sr[i-1];
          end
        end
      end

      assign active = act_sr[SYNC_DELAY-1];
      assign hsync  = hs_sr[SYNC_DELAY-1];
      assign vsync  = vs_sr[SYNC_DELAY-1];
    end
  endgenerate

  assign blank_n     = active;
  assign col         = x[XW-1:CWL];
  assign cell_px     = x[CWL-1:0];
  assign row         = y[YW-1:CHL];
  assign cell_py     = y[CHL-1:0];
  assign line_start  = pix_en && (x == '0);
  assign frame_start = pix_en && (x == '0) && (y == '0);
  assign blink       = frame_cnt[BLINK_BIT];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen. Three instances
// (defaults, a mid-size delayed config, a tiny CLK_DIV=1 config) share one
// clock and a randomly pulsed reset. Expected outputs come from a pixel-count
// model: after n pixel ticks the position is n mod H_TOTAL, etc.
module tb_vga_timing_gen;

  localparam int NCYC = 30000;

  typedef struct packed {
    logic [31:0] ha, hf, hs, hb, va, vf, vs, vb, hpol, vpol, div, dly, cw, ch, bb;
  } cfg_t;

  typedef struct packed {
    logic [31:0] pe, x, y, col, row, cpx, cpy, act, bn, hs, vs, ls, fs, fc, bl;
  } obs_t;

  localparam cfg_t CFG_A = '{ha:20, hf:3, hs:4, hb:5, va:10, vf:2, vs:2, vb:3,
                             hpol:0, vpol:1, div:3, dly:2, cw:4, ch:4, bb:1};
  localparam cfg_t CFG_B = '{ha:4, hf:1, hs:2, hb:1, va:3, vf:1, vs:1, vb:1,
                             hpol:1, vpol:1, div:1, dly:0, cw:2, ch:2, bb:0};
  localparam cfg_t CFG_C = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33,
                             hpol:0, vpol:0, div:2, dly:0, cw:8, ch:16, bb:4};

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  always #10 CLOCK_50 = ~CLOCK_50;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned c       = 0;

  // ---------------- DUT A: mid-size, delayed syncs ----------------
  logic a_pe, a_act, a_bn, a_hs, a_vs, a_ls, a_fs, a_bl;
  logic [4:0] a_x, a_y;
  logic [2:0] a_col, a_row;
  logic [1:0] a_cpx, a_cpy;
  logic [15:0] a_fc;
  vga_timing_gen #(.H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
                   .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
                   .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(3), .SYNC_DELAY(2),
                   .CELL_W(4), .CELL_H(4), .BLINK_BIT(1)) u_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .pix_en(a_pe), .x(a_x), .y(a_y),
    .col(a_col), .row(a_row), .cell_px(a_cpx), .cell_py(a_cpy),
    .active(a_act), .blank_n(a_bn), .hsync(a_hs), .vsync(a_vs),
    .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc), .blink(a_bl));

  // ---------------- DUT B: tiny, CLK_DIV=1, positive syncs ----------------
  logic b_pe, b_act, b_bn, b_hs, b_vs, b_ls, b_fs, b_bl;
  logic [2:0] b_x, b_y;
  logic [1:0] b_col, b_row;
  logic       b_cpx, b_cpy;
  logic [15:0] b_fc;
  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .SYNC_DELAY(0),
                   .CELL_W(2), .CELL_H(2), .BLINK_BIT(0)) u_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .pix_en(b_pe), .x(b_x), .y(b_y),
    .col(b_col), .row(b_row), .cell_px(b_cpx), .cell_py(b_cpy),
    .active(b_act), .blank_n(b_bn), .hsync(b_hs), .vsync(b_vs),
    .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc), .blink(b_bl));

  // ---------------- DUT C: default 640x480 ----------------
  logic c_pe, c_act, c_bn, c_hs, c_vs, c_ls, c_fs, c_bl;
  logic [9:0] c_x, c_y;
  logic [6:0] c_col;
  logic [5:0] c_row;
  logic [2:0] c_cpx;
  logic [3:0] c_cpy;
  logic [15:0] c_fc;
  vga_timing_gen u_c (
    .CLOCK_50(CLOCK_50), .reset(reset), .pix_en(c_pe), .x(c_x), .y(c_y),
    .col(c_col), .row(c_row), .cell_px(c_cpx), .cell_py(c_cpy),
    .active(c_act), .blank_n(c_bn), .hsync(c_hs), .vsync(c_vs),
    .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_fc), .blink(c_bl));

  obs_t got_a, got_b, got_c;
  assign got_a = '{pe:32'(a_pe), x:32'(a_x), y:32'(a_y), col:32'(a_col), row:32'(a_row),
                   cpx:32'(a_cpx), cpy:32'(a_cpy), act:32'(a_act), bn:32'(a_bn),
                   hs:32'(a_hs), vs:32'(a_vs), ls:32'(a_ls), fs:32'(a_fs),
                   fc:32'(a_fc), bl:32'(a_bl)};
  assign got_b = '{pe:32'(b_pe), x:32'(b_x), y:32'(b_y), col:32'(b_col), row:32'(b_row),
                   cpx:32'(b_cpx), cpy:32'(b_cpy), act:32'(b_act), bn:32'(b_bn),
                   hs:32'(b_hs), vs:32'(b_vs), ls:32'(b_ls), fs:32'(b_fs),
                   fc:32'(b_fc), bl:32'(b_bl)};
  assign got_c = '{pe:32'(c_pe), x:32'(c_x), y:32'(c_y), col:32'(c_col), row:32'(c_row),
                   cpx:32'(c_cpx), cpy:32'(c_cpy), act:32'(c_act), bn:32'(c_bn),
                   hs:32'(c_hs), vs:32'(c_vs), ls:32'(c_ls), fs:32'(c_fs),
                   fc:32'(c_fc), bl:32'(c_bl)};

  // Reference: c = clock edges since reset released (0 = reset state).
  // Pixel ticks land at c = div, 2*div, ...; counters reflect ticks already
  // consumed; delayed outputs reflect the position dly ticks earlier.
  function automatic obs_t model(cfg_t k, int unsigned cc);
    obs_t o;
    int unsigned ht, vt, m, n, xx, yy;
    o  = '0;
    ht = k.ha + k.hf + k.hs + k.hb;
    vt = k.va + k.vf + k.vs + k.vb;
    o.pe  = (cc >= 1 && (cc % k.div) == 0) ? 1 : 0;
    m     = (cc == 0) ? 0 : (cc - 1) / k.div;
    o.x   = m % ht;
    o.y   = (m / ht) % vt;
    o.fc  = (m / (ht * vt)) % 65536;
    o.col = o.x / k.cw;
    o.cpx = o.x % k.cw;
    o.row = o.y / k.ch;
    o.cpy = o.y % k.ch;
    if (m >= k.dly) begin
      n   = m - k.dly;
      xx  = n % ht;
      yy  = (n / ht) % vt;
      o.act = (xx < k.ha && yy < k.va) ? 1 : 0;
      o.hs  = (xx >= k.ha + k.hf && xx < k.ha + k.hf + k.hs) ? k.hpol : (k.hpol ^ 1);
      o.vs  = (yy >= k.va + k.vf && yy < k.va + k.vf + k.vs) ? k.vpol : (k.vpol ^ 1);
    end else begin
      o.act = 0;
      o.hs  = k.hpol ^ 1;
      o.vs  = k.vpol ^ 1;
    end
    o.bn = o.act;
    o.ls = (o.pe == 1 && o.x == 0) ? 1 : 0;
    o.fs = (o.ls == 1 && o.y == 0) ? 1 : 0;
    o.bl = (o.fc >> k.bb) & 1;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("pe%0d x%0d y%0d col%0d row%0d px%0d py%0d act%0d bn%0d hs%0d vs%0d ls%0d fs%0d fc%0d bl%0d",
                     o.pe, o.x, o.y, o.col, o.row, o.cpx, o.cpy, o.act, o.bn,
                     o.hs, o.vs, o.ls, o.fs, o.fc, o.bl);
  endfunction

  obs_t qa[$], qb[$], qc[$];

  task automatic compare(string nm, obs_t got, obs_t exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got %s want %s", nm, $time, fmt(got), fmt(exp));
  endtask

  // Monitor: pops one expectation per DUT per cycle, away from the edge.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (qa.size() > 0) compare("dutA", got_a, qa.pop_front());
      if (qb.size() > 0) compare("dutB", got_b, qb.pop_front());
      if (qc.size() > 0) compare("dutC", got_c, qc.pop_front());
    end
  end

  // Stimulus: reset held for the first cycles, two fixed mid-frame pulses,
  // plus rare random pulses; expectations pushed right after each edge.
  initial begin
    for (int i = 0; i < NCYC; i++) begin
      @(posedge CLOCK_50);
      if (reset) c = 0;
      else       c = c + 1;
      qa.push_back(model(CFG_A, c));
      qb.push_back(model(CFG_B, c));
      qc.push_back(model(CFG_C, c));
      #1;
      if (i < 3 || i == 9000 || i == 21457) reset = 1'b1;
      else reset = ($urandom_range(0, 7999) == 0);
    end
    @(negedge CLOCK_50);
    #1;
    n_total++;
    if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0) n_pass++;
    else $display("FAIL drain left %0d/%0d/%0d want 0/0/0", qa.size(), qb.size(), qc.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
